e_mdu: RTL

//  Execute-stage multiply/divide unit; consumes instruction, rs and rt values from the ID/EX register.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/e_mdu_if.sv | 26 ++
 rtl/mdu_arith.sv | 57 +++++
 rtl/e_mdu.sv | 79 +++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes and helpers for the execute-stage multiply/divide unit.
// MDU_MADD_EN enables the madd/msub family in the busy-op predicate.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int cnt_w(input int m, input int d);
    return $clog2(((m > d) ? m : d) + 1);
  endfunction

  localparam int CNT_W = cnt_w(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_md_busy_op(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU)
          || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU bundle: op request, operands, status and HI/LO readout.
// Master is the execute stage, slave is the MDU.
interface e_mdu_if;
  import mdu_pkg::*;

  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_stall;
  logic [31:0] rd_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, a, b,
    input  busy, md_stall, rd_data, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, md_stall, rd_data, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath: latched operands + HI/LO -> {HI,LO} update.
// MDU_MADD_EN adds accumulate/subtract ops on the current {HI,LO}.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        we
);

  logic [63:0] sp;
  logic [63:0] up;
  logic        nz;
  logic        ovf;
  logic [31:0] bd;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign up = {32'b0, a} * {32'b0, b};

  // Divisor of 1 on /0 and MIN/-1 keeps the divider defined;
  // MIN/1 already yields the required MIN quotient, 0 remainder.
  assign nz  = (b != 32'b0);
  assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign bd  = (!nz || ovf) ? 32'd1 : b;

  assign sq = $signed(a) / $signed(bd);
  assign sr = $signed(a) % $signed(bd);
  assign uq = a / bd;
  assign ur = a % bd;

  always_comb begin
    res = {hi, lo};
    we  = 1'b0;
    case (op)
      MDU_MULT:  begin res = sp; we = 1'b1; end
      MDU_MULTU: begin res = up; we = 1'b1; end
      MDU_DIV:   begin res = {sr, sq}; we = nz; end
      MDU_DIVU:  begin res = {ur, uq}; we = nz; end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin res = {hi, lo} + sp; we = 1'b1; end
      MDU_MADDU: begin res = {hi, lo} + up; we = 1'b1; end
      MDU_MSUB:  begin res = {hi, lo} - sp; we = 1'b1; end
      MDU_MSUBU: begin res = {hi, lo} - up; we = 1'b1; end
`endif
      default:   ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: HI/LO owner with busy-counter latency model.
// MDU_MADD_EN enables madd/maddu/msub/msubu.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave mdu
);

  localparam int CW = cnt_w(MULT_CYCLES, DIV_CYCLES);

  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [63:0]   res;
  logic          we;
  logic          md_op;

  assign md_op = is_md_busy_op(mdu.op);

  mdu_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .hi  (hi),
    .lo  (lo),
    .res (res),
    .we  (we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (we) {hi, lo} <= res;
      end
    end else if (mdu.start) begin
      unique case (1'b1)
        md_op: begin
          op_q <= mdu.op;
          a_q  <= mdu.a;
          b_q  <= mdu.b;
          busy <= 1'b1;
          cnt  <= is_div_op(mdu.op) ? CW'(DIV_CYCLES)
                                    : CW'(MULT_CYCLES);
        end
        (mdu.op == MDU_MTHI): hi <= mdu.a;
        (mdu.op == MDU_MTLO): lo <= mdu.a;
        default: ;
      endcase
    end
  end

  assign mdu.busy     = busy;
  assign mdu.md_stall = busy | (mdu.start & md_op);
  assign mdu.hi_out   = hi;
  assign mdu.lo_out   = lo;
  assign mdu.rd_data  = (mdu.op == MDU_MFHI) ? hi
                      : (mdu.op == MDU_MFLO) ? lo
                      : 32'b0;

endmodule
